// File: rtl/mem_axi_bridge_pkg.sv
// mem_axi_bridge_pkg
//   Shared definitions for the core data-side AXI4-Lite bridge: bus widths,
//   AXI response/protection constants, bridge state encodings and a small
//   response-decoding helper.
package mem_axi_bridge_pkg;

  localparam int BUS_ADDR_MEM = 64;
  localparam int BUS_DATA_MEM = 64;
  localparam int BUS_AXI_STRB = BUS_DATA_MEM / 8;

  localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  typedef logic [1:0] bus_axi_resp_t;

  typedef enum logic [2:0] {
    BRG_IDLE = 3'd0,
    BRG_WR   = 3'd1,
    BRG_WB   = 3'd2,
    BRG_RA   = 3'd3,
    BRG_RD   = 3'd4,
    BRG_DONE = 3'd5
  } brg_state_e;

  // Any response other than OKAY (SLVERR, DECERR, EXOKAY) is treated as a
  // failed access for a non-exclusive AXI4-Lite master.
  function automatic logic resp_is_err(input bus_axi_resp_t resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/mem_axi_bridge.sv
// mem_axi_bridge
//   Data-side bus master sitting directly behind the core's memory-access
//   outputs. Turns a single-cycle load/store request into AXI4-Lite
//   transactions, one outstanding at a time, and stalls the core until the
//   transaction has finished. A simultaneous store+load performs the write
//   first, then the read.
//
// Parameters
//   ADDR_W       address width
//   DATA_W       data width (strobe width DATA_W/8)
//   TIMEOUT_CYC  watchdog limit in cycles (only with AXI_TIMEOUT_EN)
//
// Optional feature (macro AXI_TIMEOUT_EN)
//   When defined, a watchdog aborts any transaction that has not finished
//   within TIMEOUT_CYC cycles: the bridge drops every valid, goes to DONE
//   with bus_err_o set, and returns zero data for loads. When undefined the
//   bridge waits on the slave indefinitely.
//
// Ports
//   clk, rst_n                core clock, asynchronous active-low reset
//   mem_wr_en_i/mem_rd_en_i   store / load request from the core
//   addr_mem_wr_i/_rd_i       store / load addresses
//   data_mem_wr_i, strb_*     store data and byte strobes
//   data_mem_o                registered load data (held until next load)
//   stall_mem_o               hold the core's request
//   bus_err_o                 one-cycle pulse in DONE when the access failed
//   m_axi_*                   AXI4-Lite master channels AW, W, B, AR, R
module mem_axi_bridge
  import mem_axi_bridge_pkg::*;
#(
  parameter int ADDR_W      = BUS_ADDR_MEM,
  parameter int DATA_W      = BUS_DATA_MEM,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // core side
  input  logic                  mem_wr_en_i,
  input  logic                  mem_rd_en_i,
  input  logic [ADDR_W-1:0]     addr_mem_wr_i,
  input  logic [ADDR_W-1:0]     addr_mem_rd_i,
  input  logic [DATA_W-1:0]     data_mem_wr_i,
  input  logic [DATA_W/8-1:0]   strb_mem_wr_i,
  output logic [DATA_W-1:0]     data_mem_o,
  output logic                  stall_mem_o,
  output logic                  bus_err_o,
  // AXI4-Lite write address
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  // AXI4-Lite write data
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  // AXI4-Lite write response
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic [1:0]            m_axi_bresp,
  // AXI4-Lite read address
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  // AXI4-Lite read data
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp
);

  brg_state_e state;

  logic aw_done;   // AW handshake already completed in WR
  logic w_done;    // W handshake already completed in WR
  logic rd_pend;   // load queued behind a simultaneous store
  logic err;       // error from the write half of a store+load pair

  // Handshake status including the handshake happening this cycle.
  logic aw_done_nx;
  logic w_done_nx;
  logic busy;

  assign aw_done_nx = aw_done | (m_axi_awvalid & m_axi_awready);
  assign w_done_nx  = w_done  | (m_axi_wvalid  & m_axi_wready);
  assign busy       = (state == BRG_WR) | (state == BRG_WB) |
                      (state == BRG_RA) | (state == BRG_RD);

  assign m_axi_awprot = AXI_PROT_DEFAULT;
  assign m_axi_arprot = AXI_PROT_DEFAULT;

  // The stall must rise in the very cycle the request appears, so it is
  // decoded from the state and the live request instead of being registered.
  always_comb begin
    stall_mem_o = 1'b1;
    case (state)
      BRG_IDLE: stall_mem_o = mem_wr_en_i | mem_rd_en_i;
      BRG_DONE: stall_mem_o = 1'b0;
      default:  stall_mem_o = 1'b1;
    endcase
  end

`ifdef AXI_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] wd_cnt;
  logic             wd_expire;

  // Held at zero while idle, so it restarts on every IDLE exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state == BRG_IDLE) begin
      wd_cnt <= '0;
    end else if (busy) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign wd_expire = busy & (wd_cnt == WD_LAST);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BRG_IDLE;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      rd_pend       <= 1'b0;
      err           <= 1'b0;
      bus_err_o     <= 1'b0;
      data_mem_o    <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_rready  <= 1'b0;
    end else begin
      // bus_err_o is a pulse: only the transition into DONE raises it.
      bus_err_o <= 1'b0;

      case (state)
        // ---- accept a request; store wins over a simultaneous load ----
        BRG_IDLE: begin
          if (mem_wr_en_i) begin
            state         <= BRG_WR;
            m_axi_awaddr  <= addr_mem_wr_i;
            m_axi_wdata   <= data_mem_wr_i;
            m_axi_wstrb   <= strb_mem_wr_i;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            rd_pend       <= mem_rd_en_i;
            if (mem_rd_en_i) begin
              m_axi_araddr <= addr_mem_rd_i;
            end
          end else if (mem_rd_en_i) begin
            state         <= BRG_RA;
            m_axi_araddr  <= addr_mem_rd_i;
            m_axi_arvalid <= 1'b1;
          end
        end

        // ---- AW and W in flight, each retired independently ----
        BRG_WR: begin
          if (m_axi_awvalid && m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
          end
          if (m_axi_wvalid && m_axi_wready) begin
            m_axi_wvalid <= 1'b0;
          end
          aw_done <= aw_done_nx;
          w_done  <= w_done_nx;
          if (aw_done_nx && w_done_nx) begin
            state        <= BRG_WB;
            m_axi_bready <= 1'b1;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
          end
        end

        // ---- wait for the write response ----
        BRG_WB: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            if (rd_pend) begin
              // Keep the write error until the trailing load reaches DONE.
              rd_pend       <= 1'b0;
              err           <= err | resp_is_err(m_axi_bresp);
              state         <= BRG_RA;
              m_axi_arvalid <= 1'b1;
            end else begin
              bus_err_o <= err | resp_is_err(m_axi_bresp);
              err       <= 1'b0;
              state     <= BRG_DONE;
            end
          end
        end

        // ---- read address in flight ----
        BRG_RA: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= BRG_RD;
          end
        end

        // ---- wait for read data; data is returned even on error ----
        BRG_RD: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            data_mem_o   <= m_axi_rdata;
            bus_err_o    <= err | resp_is_err(m_axi_rresp);
            err          <= 1'b0;
            state        <= BRG_DONE;
          end
        end

        // ---- single release cycle; the request still visible here
        //      belongs to the instruction that just completed ----
        BRG_DONE: begin
          state <= BRG_IDLE;
        end

        default: begin
          state <= BRG_IDLE;
        end
      endcase

`ifdef AXI_TIMEOUT_EN
      // Watchdog abort overrides whatever the state handler decided.
      if (wd_expire) begin
        state         <= BRG_DONE;
        m_axi_awvalid <= 1'b0;
        m_axi_wvalid  <= 1'b0;
        m_axi_bready  <= 1'b0;
        m_axi_arvalid <= 1'b0;
        m_axi_rready  <= 1'b0;
        aw_done       <= 1'b0;
        w_done        <= 1'b0;
        rd_pend       <= 1'b0;
        err           <= 1'b0;
        bus_err_o     <= 1'b1;
        if ((state == BRG_RA) || (state == BRG_RD) || rd_pend) begin
          data_mem_o <= '0;
        end
      end
`endif
    end
  end

endmodule

// File: doc/mem_axi_bridge.md
Name: mem_axi_bridge

Overview:
- Data-side bus master directly downstream of the pipeline core's memory-access outputs.
- Converts the core's single-cycle load/store request (enable, address, data, strobe) into AXI4-Lite master transactions.
- Returns `stall_mem` and the read data the core consumes.
- One outstanding transaction at a time; the core holds its request stable while `stall_mem_o` is high.

Parameters:
- ADDR_W, 64, address width (matches BUS_ADDR_MEM).
- DATA_W, 64, data width (matches BUS_DATA_MEM); strobe width is DATA_W/8.
- TIMEOUT_CYC, 256, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_wr_en_i  in  1  core store request.
- mem_rd_en_i  in  1  core load request.
- addr_mem_wr_i  in  ADDR_W  store address.
- addr_mem_rd_i  in  ADDR_W  load address.
- data_mem_wr_i  in  DATA_W  store data.
- strb_mem_wr_i  in  DATA_W/8  store byte strobes.
- data_mem_o  out  DATA_W  load data to core, registered.
- stall_mem_o  out  1  hold request to core.
- bus_err_o  out  1  one-cycle pulse: transaction failed.
- m_axi_awvalid/awready  out/in  1  AW handshake.
- m_axi_awaddr  out  ADDR_W  write address.
- m_axi_awprot  out  3  tied 3'b000.
- m_axi_wvalid/wready  out/in  1  W handshake.
- m_axi_wdata  out  DATA_W  write data.
- m_axi_wstrb  out  DATA_W/8  write strobes.
- m_axi_bvalid/bready  in/out  1  B handshake.
- m_axi_bresp  in  2  write response.
- m_axi_arvalid/arready  out/in  1  AR handshake.
- m_axi_araddr  out  ADDR_W  read address.
- m_axi_arprot  out  3  tied 3'b000.
- m_axi_rvalid/rready  in/out  1  R handshake.
- m_axi_rdata  in  DATA_W  read data.
- m_axi_rresp  in  2  read response.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All valid/ready outputs are 0.
  - data_mem_o, bus_err_o, the address/data registers and the internal flags are 0.
  - A reset during a transaction abandons it without completion.
- States: IDLE, WR (AW and W in flight), WB (wait B), RA (AR in flight), RD (wait R), DONE.
- IDLE:
  - Wr request → WR, with address, data and strobe latched at the edge.
  - Otherwise rd request → RA, with address latched.
  - stall_mem_o = mem_wr_en_i | mem_rd_en_i (combinational, same cycle as the request).
- Simultaneous wr and rd:
  - The write is performed first.
  - A pending-read flag is set; WB then goes to RA instead of DONE.
  - The read address is latched at IDLE exit.
- WR:
  - awvalid and wvalid are asserted together from the cycle after IDLE exit.
  - aw_done and w_done flags are tracked independently; each valid drops after its own handshake.
  - When both flags are set → WB. No valid is deasserted before its handshake.
- WB:
  - bready=1.
  - On bvalid: latch err if bresp≠2'b00; go to RA if the read is pending, else DONE.
- RA: arvalid=1 until arready, then → RD.
- RD:
  - rready=1.
  - On rvalid: latch rdata into data_mem_o, latch err if rresp≠2'b00, → DONE.
  - On error the returned rdata is still loaded.
- DONE:
  - Lasts exactly one cycle with stall_mem_o=0.
  - bus_err_o = latched err; err is cleared.
  - The core advances on this edge.
  - Requests seen in DONE are ignored, since they belong to the just-finished instruction. → IDLE.
- stall_mem_o = 1 in every state except DONE, and in IDLE only when a request is present.
- Minimum latency with zero-wait slave:
  - Load: request cycle + RA + RD + DONE, giving 3 stall cycles.
  - Store: IDLE + WR + WB, then DONE.
- data_mem_o holds its value until the next read completes; it is not cleared on a store.

Optional Feature:
- AXI_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYC)+1 resets on IDLE exit and increments in WR/WB/RA/RD.
  - On reaching TIMEOUT_CYC-1: → DONE, bus_err_o=1, data_mem_o=0 for reads, all valids dropped, and any pending read discarded.
- Undefined: no counter; the bridge waits indefinitely.

Decomposition:
- Shared define file gets:
  - AXI_RESP_OKAY (2'b00) and AXI_PROT_DEFAULT (3'b000).
  - State encodings BRG_IDLE..BRG_DONE (3 bits).
  - BUS_AXI_RESP [1:0].
- Widths reuse BUS_ADDR_MEM, BUS_DATA_MEM and BUS_AXI_STRB.
- No sub-module; the optional watchdog stays inline.

Test Plan:
- Load at addr 0x8000_0010 with slave returning 0xDEAD_BEEF_0123_4567, zero wait → stall_mem_o high for 3 cycles, data_mem_o=0xDEAD_BEEF_0123_4567 in DONE, bus_err_o=0.
- Store data 0x11, strb 0x01, slave wready 3 cycles after awready → awaddr/wdata/wstrb stable until each handshake, WB entered only after both, single DONE cycle.
- wr_en and rd_en in the same cycle (wr 0x100, rd 0x200) → AW/W complete before AR issued, araddr=0x200, one DONE at the end.
- rresp=2'b10 on a load → bus_err_o pulses for 1 cycle in DONE, data_mem_o = returned rdata.
- rst_n deasserted while in RD with rvalid pending → all outputs 0 immediately, rready=0, IDLE after release.
- With AXI_TIMEOUT_EN and arready held 0 → DONE after TIMEOUT_CYC cycles, bus_err_o=1, data_mem_o=0.
